// File: rtl/control_sequencer_pkg.sv
// Shared opcode, micro-step and control-word bit definitions for the CPU
// control sequencer, its datapath consumers and the testbench.
package cpu_ctrl_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int STEP_W       = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Bit positions inside the packed control word
  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_RAM_OUT  = 4;
  localparam int CW_RAM_IN   = 5;
  localparam int CW_IR_LOAD  = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_LOAD   = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LOAD   = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_SUB      = 12;
  localparam int CW_OUT_LOAD = 13;
  localparam int CW_W        = 14;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// opcode and ALU flags in, every strobe plus status out.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    CF;
  logic                    ZF;
  logic                    pc_out;
  logic                    pc_inc;
  logic                    pc_load;
  logic                    mar_load;
  logic                    ram_out;
  logic                    ram_in;
  logic                    ir_load;
  logic                    ir_out;
  logic                    a_load;
  logic                    a_out;
  logic                    b_load;
  logic                    alu_out;
  logic                    sub;
  logic                    out_load;
  logic                    halted;
  logic [STEP_W-1:0]       step;

  modport master (
    input  opcode, CF, ZF,
    output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load,
           ir_out, a_load, a_out, b_load, alu_out, sub, out_load, halted, step
  );

  modport slave (
    output opcode, CF, ZF,
    input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load,
           ir_out, a_load, a_out, b_load, alu_out, sub, out_load, halted, step
  );

endinterface

// File: rtl/control_sequencer_step_counter.sv
// Micro-step counter: wraps to T0 on clear_i or after LAST_STEP, freezes on hold_i.
module step_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int LAST_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              hold_i,
  output logic [STEP_W-1:0] step_o
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    step_d = step_q + 3'd1;
    if (hold_i) begin
      step_d = step_q;
    end else if (clear_i || (step_q >= STEP_W'(LAST_STEP))) begin
      step_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: decodes (step, opcode, CF, ZF) into the datapath
// control word and tracks the halted state.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int LAST_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  logic [OPCODE_W-1:0] op;
  logic [STEP_W-1:0]   step;
  logic [CW_W-1:0]     cw;
  logic                endStep;
  logic                halted_q;
  logic                halted_d;

  assign op = bus.opcode;

  step_counter #(.LAST_STEP(LAST_STEP)) u_step_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (endStep),
    .hold_i  (halted_q),
    .step_o  (step)
  );

  // Strobes are forced low during reset and once halted.
  always_comb begin
    cw      = '0;
    endStep = 1'b0;
    if (!rst && !halted_q) begin
      case (step)
        T0: begin
          cw[CW_PC_OUT]   = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        T1: begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_IR_LOAD] = 1'b1;
          cw[CW_PC_INC]  = 1'b1;
        end
        T2: begin
          endStep = 1'b1;
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw[CW_IR_OUT]   = 1'b1;
              cw[CW_MAR_LOAD] = 1'b1;
              endStep         = 1'b0;
            end
            OP_LDI: begin
              cw[CW_IR_OUT] = 1'b1;
              cw[CW_A_LOAD] = 1'b1;
            end
            OP_JMP: begin
              cw[CW_IR_OUT]  = 1'b1;
              cw[CW_PC_LOAD] = 1'b1;
            end
            OP_JC: begin
              cw[CW_IR_OUT]  = bus.CF;
              cw[CW_PC_LOAD] = bus.CF;
            end
            OP_JZ: begin
              cw[CW_IR_OUT]  = bus.ZF;
              cw[CW_PC_LOAD] = bus.ZF;
            end
            OP_OUT: begin
              cw[CW_A_OUT]    = 1'b1;
              cw[CW_OUT_LOAD] = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          endStep = 1'b1;
          case (op)
            OP_LDA: begin
              cw[CW_RAM_OUT] = 1'b1;
              cw[CW_A_LOAD]  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_RAM_OUT] = 1'b1;
              cw[CW_B_LOAD]  = 1'b1;
              endStep        = 1'b0;
            end
            OP_STA: begin
              cw[CW_A_OUT]  = 1'b1;
              cw[CW_RAM_IN] = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          endStep = 1'b1;
          if (op == OP_ADD || op == OP_SUB) begin
            cw[CW_ALU_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            cw[CW_SUB]     = (op == OP_SUB);
          end
        end
        default: endStep = 1'b1;
      endcase
    end
  end

  always_comb begin
    halted_d = halted_q;
    if (!halted_q && (step == T2) && (op == OP_HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign bus.pc_out   = cw[CW_PC_OUT];
  assign bus.pc_inc   = cw[CW_PC_INC];
  assign bus.pc_load  = cw[CW_PC_LOAD];
  assign bus.mar_load = cw[CW_MAR_LOAD];
  assign bus.ram_out  = cw[CW_RAM_OUT];
  assign bus.ram_in   = cw[CW_RAM_IN];
  assign bus.ir_load  = cw[CW_IR_LOAD];
  assign bus.ir_out   = cw[CW_IR_OUT];
  assign bus.a_load   = cw[CW_A_LOAD];
  assign bus.a_out    = cw[CW_A_OUT];
  assign bus.b_load   = cw[CW_B_LOAD];
  assign bus.alu_out  = cw[CW_ALU_OUT];
  assign bus.sub      = cw[CW_SUB];
  assign bus.out_load = cw[CW_OUT_LOAD];
  assign bus.halted   = halted_q;
  assign bus.step     = step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and random-stream checks of the control sequencer microcode,
// reset behaviour, conditional jumps and halt.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  control_sequencer_if bus ();

  control_sequencer #(.OPCODE_W(4), .LAST_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [CW_W-1:0] sb(input int idx);
    return CW_W'(1) << idx;
  endfunction

  function automatic logic [CW_W-1:0] observedCw();
    logic [CW_W-1:0] w;
    w = '0;
    w[CW_PC_OUT]   = bus.pc_out;
    w[CW_PC_INC]   = bus.pc_inc;
    w[CW_PC_LOAD]  = bus.pc_load;
    w[CW_MAR_LOAD] = bus.mar_load;
    w[CW_RAM_OUT]  = bus.ram_out;
    w[CW_RAM_IN]   = bus.ram_in;
    w[CW_IR_LOAD]  = bus.ir_load;
    w[CW_IR_OUT]   = bus.ir_out;
    w[CW_A_LOAD]   = bus.a_load;
    w[CW_A_OUT]    = bus.a_out;
    w[CW_B_LOAD]   = bus.b_load;
    w[CW_ALU_OUT]  = bus.alu_out;
    w[CW_SUB]      = bus.sub;
    w[CW_OUT_LOAD] = bus.out_load;
    return w;
  endfunction

  // Fetch words shared by every instruction
  logic [CW_W-1:0] wT0;
  logic [CW_W-1:0] wT1;

  task automatic test_reset();
    logic [CW_W+3:0] got;
    rst = 1'b1;
    bus.opcode = OP_NOP;
    bus.CF = 1'b0;
    bus.ZF = 1'b0;
    #2;
    got = {bus.halted, bus.step, observedCw()};
    checks++;
    if (got !== {1'b0, 3'd0, 14'h0})
      $display("[TB] FAIL reset_state got=%h expected=%h", got, {1'b0, 3'd0, 14'h0});
    if (got !== {1'b0, 3'd0, 14'h0}) errors++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    got = {bus.halted, bus.step, observedCw()};
    checks++;
    if (got !== {1'b0, 3'd0, wT0}) begin
      errors++;
      $display("[TB] FAIL reset_release_t0 got=%h expected=%h", got, {1'b0, 3'd0, wT0});
    end
  endtask

  task automatic test_alu(input logic [3:0] op);
    logic [CW_W-1:0] exp [5];
    logic [CW_W+2:0] got;
    exp[0] = wT0;
    exp[1] = wT1;
    exp[2] = sb(CW_IR_OUT) | sb(CW_MAR_LOAD);
    exp[3] = sb(CW_RAM_OUT) | sb(CW_B_LOAD);
    exp[4] = sb(CW_ALU_OUT) | sb(CW_A_LOAD) | ((op == OP_SUB) ? sb(CW_SUB) : '0);
    bus.opcode = op;
    bus.CF = 1'b1;
    bus.ZF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      got = {bus.step, observedCw()};
      checks++;
      if (got !== {3'(i), exp[i]}) begin
        errors++;
        $display("[TB] FAIL alu_op%0h_t%0d got=%h expected=%h", op, i, got, {3'(i), exp[i]});
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (bus.step !== 3'd0) begin
      errors++;
      $display("[TB] FAIL alu_op%0h_wrap got=%0d expected=0", op, bus.step);
    end
  endtask

  task automatic test_ldi();
    logic [CW_W-1:0] exp [3];
    logic [CW_W+2:0] got;
    exp[0] = wT0;
    exp[1] = wT1;
    exp[2] = sb(CW_IR_OUT) | sb(CW_A_LOAD);
    bus.opcode = OP_LDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {bus.step, observedCw()};
      checks++;
      if (got !== {3'(i), exp[i]}) begin
        errors++;
        $display("[TB] FAIL ldi_t%0d got=%h expected=%h", i, got, {3'(i), exp[i]});
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (bus.step !== 3'd0) begin
      errors++;
      $display("[TB] FAIL ldi_wrap got=%0d expected=0", bus.step);
    end
  endtask

  task automatic test_misc_ops();
    logic [3:0]      ops  [10] = '{4'h0, 4'h1, 4'h4, 4'h6, 4'hE, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
    int              lens [10] = '{3, 4, 4, 3, 3, 3, 3, 3, 3, 3};
    logic [CW_W-1:0] w2   [10];
    logic [CW_W-1:0] w3   [10];
    logic [CW_W-1:0] expW;
    logic [CW_W+2:0] got;
    for (int k = 0; k < 10; k++) begin
      w2[k] = '0;
      w3[k] = '0;
    end
    w2[1] = sb(CW_IR_OUT) | sb(CW_MAR_LOAD);
    w3[1] = sb(CW_RAM_OUT) | sb(CW_A_LOAD);
    w2[2] = sb(CW_IR_OUT) | sb(CW_MAR_LOAD);
    w3[2] = sb(CW_A_OUT) | sb(CW_RAM_IN);
    w2[3] = sb(CW_IR_OUT) | sb(CW_PC_LOAD);
    w2[4] = sb(CW_A_OUT) | sb(CW_OUT_LOAD);
    for (int k = 0; k < 10; k++) begin
      bus.opcode = ops[k];
      bus.CF = k[0];
      bus.ZF = k[1];
      for (int i = 0; i < lens[k]; i++) begin
        expW = (i == 0) ? wT0 : (i == 1) ? wT1 : (i == 2) ? w2[k] : w3[k];
        #1;
        got = {bus.step, observedCw()};
        checks++;
        if (got !== {3'(i), expW}) begin
          errors++;
          $display("[TB] FAIL op%0h_t%0d got=%h expected=%h", ops[k], i, got, {3'(i), expW});
        end
        @(posedge clk); #1;
      end
    end
    #1;
    checks++;
    if (bus.step !== 3'd0) begin
      errors++;
      $display("[TB] FAIL misc_wrap got=%0d expected=0", bus.step);
    end
  endtask

  task automatic test_cond_jumps();
    logic [3:0]      ops   [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
    logic            cfs   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic            zfs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic            taken [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [CW_W-1:0] expW;
    logic [CW_W+2:0] got;
    for (int k = 0; k < 4; k++) begin
      bus.opcode = ops[k];
      bus.CF = cfs[k];
      bus.ZF = zfs[k];
      for (int i = 0; i < 3; i++) begin
        expW = (i == 0) ? wT0 : (i == 1) ? wT1 :
               (taken[k] ? (sb(CW_IR_OUT) | sb(CW_PC_LOAD)) : '0);
        #1;
        got = {bus.step, observedCw()};
        checks++;
        if (got !== {3'(i), expW}) begin
          errors++;
          $display("[TB] FAIL jump_op%0h_cf%0d_zf%0d_t%0d got=%h expected=%h",
                   ops[k], cfs[k], zfs[k], i, got, {3'(i), expW});
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [CW_W+3:0] got;
    bus.opcode = OP_ADD;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.step !== 3'd3) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre got=%0d expected=3", bus.step);
    end
    rst = 1'b1;
    #1;
    got = {bus.halted, bus.step, observedCw()};
    checks++;
    if (got !== {1'b0, 3'd0, 14'h0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got=%h expected=%h", got, {1'b0, 3'd0, 14'h0});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.step, observedCw()} !== {3'd0, 14'h0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_held got=%h expected=0", {bus.step, observedCw()});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.step, observedCw()} !== {3'd0, wT0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_t0 got=%h expected=%h", {bus.step, observedCw()}, {3'd0, wT0});
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    int         expStep;
    int         lastStep;
    int         drivers;
    op = 4'h0;
    expStep = 0;
    lastStep = 2;
    for (int c = 0; (c < 1000) || (expStep != 0); c++) begin
      if (expStep == 0) begin
        op = 4'($urandom_range(0, 14));
        lastStep = (op == 4'h1 || op == 4'h4) ? 3 : (op == 4'h2 || op == 4'h3) ? 4 : 2;
        bus.opcode = op;
      end
      bus.CF = 1'($urandom_range(0, 1));
      bus.ZF = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.step !== 3'(expStep)) begin
        errors++;
        $display("[TB] FAIL random_step cycle=%0d op=%0h got=%0d expected=%0d", c, op, bus.step, expStep);
      end
      drivers = $countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out});
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("[TB] FAIL random_bus_drivers cycle=%0d got=%0d expected<=1", c, drivers);
      end
      expStep = (expStep == lastStep) ? 0 : expStep + 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic [CW_W+3:0] got;
    logic [CW_W-1:0] exp [3];
    exp[0] = wT0;
    exp[1] = wT1;
    exp[2] = '0;
    bus.opcode = OP_HLT;
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {bus.halted, bus.step, observedCw()};
      checks++;
      if (got !== {1'b0, 3'(i), exp[i]}) begin
        errors++;
        $display("[TB] FAIL hlt_t%0d got=%h expected=%h", i, got, {1'b0, 3'(i), exp[i]});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      got = {bus.halted, bus.step, observedCw()};
      checks++;
      if (got !== {1'b1, 3'd0, 14'h0}) begin
        errors++;
        $display("[TB] FAIL halted_idle_%0d got=%h expected=%h", i, got, {1'b1, 3'd0, 14'h0});
      end
      bus.opcode = 4'($urandom_range(0, 15));
      bus.CF = 1'($urandom_range(0, 1));
      bus.ZF = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.halted, bus.step} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL halt_reset got=%h expected=0", {bus.halted, bus.step});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.halted, observedCw()} !== {1'b0, wT0}) begin
      errors++;
      $display("[TB] FAIL halt_release got=%h expected=%h", {bus.halted, observedCw()}, {1'b0, wT0});
    end
  endtask

  initial begin
    wT0 = sb(CW_PC_OUT) | sb(CW_MAR_LOAD);
    wT1 = sb(CW_RAM_OUT) | sb(CW_IR_LOAD) | sb(CW_PC_INC);
    test_reset();
    test_alu(OP_ADD);
    test_alu(OP_SUB);
    test_ldi();
    test_misc_ops();
    test_cond_jumps();
    test_reset_mid();
    test_random();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
